// File: rtl/rfphoenix_valu_sched_pkg.sv
// rfphoenix_valu_sched_pkg: shared types and defaults for the vector ALU issue scheduler.
package rfphoenix_valu_sched_pkg;
  localparam int NLANES = 4;
  localparam int LANEW = 32;
  localparam int VALU_NTHREADS = 4;
  localparam int VALU_LAT = 3;
  localparam int TIDW = $clog2(VALU_NTHREADS);
  typedef logic [31:0] Instruction;
  typedef logic [NLANES*LANEW-1:0] VecValue;
  typedef logic [TIDW-1:0] tid_t;
  typedef struct packed {
    logic v;
    tid_t tid;
    logic tt;
  } valu_tag_t;
endpackage

// File: rtl/rfphoenix_valu_sched_rr_arb.sv
// rfphoenix_rr_arb: round-robin pick of the first requester at or after ptr.
module rfphoenix_rr_arb #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] id,
  output logic         any
);
  logic [W-1:0] idx;
  // Walk the search order backwards so the requester nearest ptr is the last write.
  always_comb begin
    id = '0;
    any = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr + W'(i);
      if (req[idx]) begin
        id = idx;
        any = 1'b1;
      end
    end
    gnt = {N{any}} & (N'(1) << id);
  end
endmodule

// File: rtl/rfphoenix_valu_sched.sv
// rfphoenix_valu_sched: round-robin issue of per-thread ops to the shared vector ALU,
// with a tag pipe tracking in-flight ops and a one-entry tagged result buffer.
module rfphoenix_valu_sched
  import rfphoenix_valu_sched_pkg::*;
#(
  parameter int NTHREADS = VALU_NTHREADS,
  parameter int LAT = VALU_LAT,
  localparam int TW = $clog2(NTHREADS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NTHREADS-1:0]                   req_valid,
  output logic [NTHREADS-1:0]                   req_ready,
  input  logic [NTHREADS*$bits(Instruction)-1:0] req_ir,
  input  logic [NTHREADS-1:0]                   req_tt,
  input  logic [NTHREADS-1:0]                   flush,
  output logic                                  issue_valid,
  output logic [TW-1:0]                         issue_tid,
  output logic [$bits(Instruction)-1:0]         issue_ir,
  output logic                                  alu_ce,
  input  logic [$bits(VecValue)-1:0]            alu_o,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [TW-1:0]                         res_tid,
  output logic                                  res_tt,
  output logic [$bits(VecValue)-1:0]            res_o,
  output logic [NTHREADS-1:0]                   busy
);
  localparam int IW = $bits(Instruction);
  typedef struct packed {
    logic v;
    logic [TW-1:0] tid;
    logic tt;
  } tag_t;
  tag_t pipe [LAT];
  tag_t src [LAT];
  logic stall, grant_any, cap;
  logic [TW-1:0] grant_id, rr_ptr;
  logic [NTHREADS-1:0] elig, drain;
  assign stall = res_valid & ~res_ready & pipe[LAT-1].v;
  assign alu_ce = rst_n & ~stall;
  // A flushing thread may not win in the same cycle it is being killed.
  assign elig = (rst_n & ~stall) ? req_valid & ~busy & ~flush : '0;
  rfphoenix_rr_arb #(.N(NTHREADS)) u_arb (
    .req(elig),
    .ptr(rr_ptr),
    .gnt(req_ready),
    .id(grant_id),
    .any(grant_any)
  );
  assign issue_valid = grant_any;
  assign issue_tid = grant_any ? grant_id : '0;
  assign issue_ir = grant_any ? req_ir[IW*grant_id +: IW] : '0;
  assign cap = alu_ce & pipe[LAT-1].v & ~flush[pipe[LAT-1].tid];
  assign drain = {NTHREADS{res_valid & res_ready}} & (NTHREADS'(1) << res_tid);
  // Next tag-pipe contents: shift on alu_ce, then kill any entry of a flushed thread.
  always_comb begin
    src[0] = alu_ce ? {grant_any, grant_id, req_tt[grant_id]} : pipe[0];
    for (int i = 1; i < LAT; i++) src[i] = alu_ce ? pipe[i-1] : pipe[i];
    for (int i = 0; i < LAT; i++) src[i].v = src[i].v & ~flush[src[i].tid];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '{default: '0};
      rr_ptr <= '0;
      busy <= '0;
      res_valid <= 1'b0;
      res_tid <= '0;
      res_tt <= 1'b0;
      res_o <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) pipe[i] <= src[i];
      if (grant_any) rr_ptr <= grant_id + TW'(1);
      busy <= (busy | req_ready) & ~flush & ~drain;
      if (cap) begin
        res_valid <= 1'b1;
        res_tid <= pipe[LAT-1].tid;
        res_tt <= pipe[LAT-1].tt;
        res_o <= alu_o;
      end else if (res_ready | flush[res_tid]) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rfphoenix_valu_sched.sv
// tb_rfphoenix_valu_sched: scenario tasks plus a queue-based reference model of the
// scheduler (ops age toward the buffer, drain in issue order, vanish on flush).
module tb_rfphoenix_valu_sched;
  import rfphoenix_valu_sched_pkg::*;
  localparam int N = 4;
  localparam int L = 3;
  localparam int TW = 2;
  localparam int IW = $bits(Instruction);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, req_tt = '0, flush = '0, busy;
  logic [N*IW-1:0] req_ir = '0;
  logic issue_valid, alu_ce, res_valid, res_tt;
  logic res_ready = 1'b0;
  logic [TW-1:0] issue_tid, res_tid;
  logic [IW-1:0] issue_ir;
  VecValue alu_o, res_o;
  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  rfphoenix_valu_sched #(.NTHREADS(N), .LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_ir(req_ir),
    .req_tt(req_tt), .flush(flush), .issue_valid(issue_valid), .issue_tid(issue_tid),
    .issue_ir(issue_ir), .alu_ce(alu_ce), .alu_o(alu_o), .res_valid(res_valid),
    .res_ready(res_ready), .res_tid(res_tid), .res_tt(res_tt), .res_o(res_o), .busy(busy)
  );

  function automatic VecValue mk(input Instruction ir);
    return {ir, ~ir, ir + 32'h1234567, {ir[15:0], ir[31:16]}};
  endfunction

  // Environment ALU: LAT-deep pipe advancing on alu_ce.
  VecValue alu_st [L];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) alu_st[i] <= '0;
    end else if (alu_ce) begin
      alu_st[0] <= issue_valid ? mk(issue_ir) : '0;
      for (int i = 1; i < L; i++) alu_st[i] <= alu_st[i-1];
    end
  end
  assign alu_o = alu_st[L-1];

  // Reference model: each op counts down L unstalled cycles, then sits in the buffer.
  typedef struct {
    int tid;
    bit tt;
    VecValue d;
    int rem;
  } op_t;
  op_t q[$];
  int rr_m = 0;
  int win, idx;
  bit fb, h1, stl;
  logic [N-1:0] mb, eready;
  logic [IW-1:0] eir;

  always @(negedge clk) begin
    if (!rst_n) begin
      vectors++;
      if ({req_ready, issue_valid, issue_tid, issue_ir, alu_ce, res_valid, res_tid, res_tt, res_o, busy} !== '0) begin
        errs++;
        $display("FAIL reset_outputs: req_ready=%b issue_valid=%b alu_ce=%b res_valid=%b busy=%b, all must be 0",
                 req_ready, issue_valid, alu_ce, res_valid, busy);
      end
      q.delete();
      rr_m = 0;
    end else begin
      fb = q.size() > 0 && q[0].rem == 0;
      h1 = 0;
      mb = '0;
      foreach (q[i]) begin
        if (q[i].rem == 1) h1 = 1;
        mb[q[i].tid] = 1'b1;
      end
      stl = fb && !res_ready && h1;
      win = -1;
      if (!stl)
        for (int k = 0; k < N; k++) begin
          idx = (rr_m + k) % N;
          if (win < 0 && req_valid[idx] && !mb[idx] && !flush[idx]) win = idx;
        end
      eready = '0;
      eir = '0;
      if (win >= 0) begin
        eready[win] = 1'b1;
        eir = req_ir[win*IW +: IW];
      end
      vectors++;
      if (alu_ce !== !stl || req_ready !== eready || issue_valid !== (win >= 0) ||
          (win >= 0 && issue_tid !== TW'(win)) || issue_ir !== eir || busy !== mb || res_valid !== fb) begin
        errs++;
        $display("FAIL cycle_outputs @%0t: got alu_ce=%b req_ready=%b issue_tid=%0d issue_ir=%h busy=%b res_valid=%b; want alu_ce=%b req_ready=%b issue_ir=%h busy=%b res_valid=%b",
                 $time, alu_ce, req_ready, issue_tid, issue_ir, busy, res_valid, !stl, eready, eir, mb, fb);
      end
      if (fb) begin
        vectors++;
        if (res_tid !== TW'(q[0].tid) || res_tt !== q[0].tt || res_o !== q[0].d) begin
          errs++;
          $display("FAIL result @%0t: got tid=%0d tt=%b o=%h; want tid=%0d tt=%b o=%h",
                   $time, res_tid, res_tt, res_o, q[0].tid, q[0].tt, q[0].d);
        end
      end
      if (fb && res_ready) void'(q.pop_front());
      for (int i = q.size() - 1; i >= 0; i--) if (flush[q[i].tid]) q.delete(i);
      if (!stl) foreach (q[i]) if (q[i].rem > 0) q[i].rem--;
      if (win >= 0) begin
        q.push_back('{win, req_tt[win], mk(eir), L});
        rr_m = (win + 1) % N;
      end
    end
  end

  task automatic cyc(input logic [N-1:0] v, input logic rdy, input logic [N-1:0] f);
    @(posedge clk);
    #1;
    req_valid = v;
    res_ready = rdy;
    flush = f;
    for (int i = 0; i < N; i++) req_ir[i*IW +: IW] = $urandom;
    req_tt = N'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    flush = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (alu_ce !== 1'b0 || req_ready !== '0 || res_valid !== 1'b0 || busy !== '0) begin
      errs++;
      $display("FAIL test_reset: alu_ce=%b req_ready=%b res_valid=%b busy=%b, want all 0", alu_ce, req_ready, res_valid, busy);
    end
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int lat = -1;
    Instruction ir;
    repeat (4) cyc('0, 1'b1, '0);
    cyc(4'b0010, 1'b1, '0);
    ir = req_ir[IW +: IW];
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      errs++;
      $display("FAIL single_grant: req_ready=%b want 0010", req_ready);
    end
    for (int n = 1; n <= 10; n++) begin
      cyc('0, 1'b1, '0);
      #1;
      if (res_valid && lat < 0) begin
        lat = n;
        vectors++;
        if (res_tid !== 2'd1 || res_o !== mk(ir)) begin
          errs++;
          $display("FAIL single_result: tid=%0d o=%h want tid=1 o=%h", res_tid, res_o, mk(ir));
        end
      end
    end
    vectors++;
    if (lat != L + 1) begin
      errs++;
      $display("FAIL single_latency: %0d cycles want %0d", lat, L + 1);
    end
  endtask

  task automatic test_round_robin();
    int k = 0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc('1, 1'b1, '0);
      #1;
      for (int t = 0; t < N; t++)
        if (req_ready[t]) begin
          vectors++;
          if (t != k % N) begin
            errs++;
            $display("FAIL rr_order: grant %0d went to %0d want %0d", k, t, k % N);
          end
          k++;
        end
    end
    vectors++;
    if (k < 12) begin
      errs++;
      $display("FAIL rr_count: %0d grants want at least 12", k);
    end
  endtask

  task automatic test_backpressure();
    VecValue snap;
    logic [TW-1:0] stid;
    int k = 0;
    do_reset();
    repeat (4) cyc('1, 1'b1, '0);
    cyc('1, 1'b0, '0);
    #1;
    snap = res_o;
    stid = res_tid;
    repeat (5) begin
      cyc('1, 1'b0, '0);
      #1;
      vectors++;
      if (alu_ce !== 1'b0 || req_ready !== '0 || res_o !== snap || res_tid !== stid || res_valid !== 1'b1) begin
        errs++;
        $display("FAIL backpressure_hold: alu_ce=%b req_ready=%b res_valid=%b res_tid=%0d want alu_ce=0 no grant tid=%0d stable",
                 alu_ce, req_ready, res_valid, res_tid, stid);
      end
    end
    repeat (10) begin
      cyc('0, 1'b1, '0);
      #1;
      if (res_valid) begin
        vectors++;
        if (res_tid !== TW'(k)) begin
          errs++;
          $display("FAIL backpressure_order: drain %0d tid=%0d want %0d", k, res_tid, k);
        end
        k++;
      end
    end
    vectors++;
    if (k != 4) begin
      errs++;
      $display("FAIL backpressure_count: %0d results drained want 4", k);
    end
  endtask

  task automatic test_flush();
    int seen1 = -1;
    do_reset();
    cyc(4'b0010, 1'b1, '0);
    cyc(4'b0100, 1'b1, '0);
    cyc('0, 1'b1, 4'b0100);
    cyc('0, 1'b1, '0);
    #1;
    vectors++;
    if (busy !== 4'b0010) begin
      errs++;
      $display("FAIL flush_busy: busy=%b want 0010", busy);
    end
    for (int n = 4; n < 12; n++) begin
      cyc('0, 1'b1, '0);
      #1;
      if (res_valid && res_tid == 2'd1 && seen1 < 0) seen1 = n;
      if (res_valid && res_tid == 2'd2) begin
        vectors++;
        errs++;
        $display("FAIL flush_leak: tid 2 result at cycle %0d, want none", n);
      end
    end
    vectors++;
    if (seen1 != L + 1) begin
      errs++;
      $display("FAIL flush_other: tid 1 result at cycle %0d want %0d", seen1, L + 1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) cyc('1, 1'b1, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (req_ready !== '0 || issue_valid !== 1'b0 || alu_ce !== 1'b0 || res_valid !== 1'b0 || busy !== '0 || issue_ir !== '0) begin
      errs++;
      $display("FAIL async_reset: req_ready=%b issue_valid=%b alu_ce=%b res_valid=%b busy=%b want all 0",
               req_ready, issue_valid, alu_ce, res_valid, busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      errs++;
      $display("FAIL async_reset_first_grant: req_ready=%b want 0001", req_ready);
    end
    repeat (8) cyc('0, 1'b1, '0);
  endtask

  task automatic test_back_to_back();
    int overlap = 0;
    int k = 0;
    bit prev = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      cyc('1, 1'b1, '0);
      #1;
      if (prev && res_valid) overlap++;
      if (res_valid) begin
        vectors++;
        if (res_tid !== TW'(k % N)) begin
          errs++;
          $display("FAIL b2b_order: result %0d tid=%0d want %0d", k, res_tid, k % N);
        end
        k++;
      end
      prev = res_valid & res_ready;
    end
    vectors++;
    if (overlap == 0 || k < 25) begin
      errs++;
      $display("FAIL b2b_throughput: overlaps=%0d results=%0d want overlaps>0 results>=25", overlap, k);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] f;
    do_reset();
    repeat (3000) begin
      for (int i = 0; i < N; i++) f[i] = ($urandom_range(0, 31) == 0);
      cyc(N'($urandom), $urandom_range(0, 3) != 0, f);
    end
    repeat (12) cyc('0, 1'b1, '0);
    #1;
    vectors++;
    if (busy !== '0 || res_valid !== 1'b0) begin
      errs++;
      $display("FAIL random_idle: busy=%b res_valid=%b want 0 after drain", busy, res_valid);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
